// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, error codes and common command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    WAIT_START,
    SEND,
    WAIT_ACK,
    WAIT_IDLE,
    ABORT
  } ps2_tx_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_XFER_TO  = 2'b10;
  localparam logic [1:0] ERR_NO_ACK   = 2'b11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 frames carry odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer with falling-edge detect for one open-drain PS/2 line.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clock out
// one odd-parity frame on device clock edges, then check the device ack.
module ps2_command_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = 6000,
  parameter int unsigned RTS_SETUP_CYCLES     = 250,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int unsigned CNT_MAX = max_u(max_u(INHIBIT_CYCLES, RTS_SETUP_CYCLES),
                                          max_u(START_TIMEOUT_CYCLES, XFER_TIMEOUT_CYCLES));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

  ps2_tx_state_t    state;
  logic [9:0]       frame;
  logic [3:0]       bitcnt;
  logic [CNT_W-1:0] cnt;

  logic clk_level;
  logic clk_fall;
  logic dat_level;
  logic dat_fall;
  logic unused_dat_fall;

  ps2_line_sync clk_sync (
    .clock (clock),
    .reset (reset),
    .line  (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_sync dat_sync (
    .clock (clock),
    .reset (reset),
    .line  (ps2_dat_in),
    .level (dat_level),
    .fall  (dat_fall)
  );

  // Data-line edges only matter to the receive path.
  assign unused_dat_fall = dat_fall;

  logic in_xfer;
  assign in_xfer = (state == SEND) || (state == WAIT_ACK) || (state == WAIT_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      frame      <= '0;
      bitcnt     <= '0;
      cnt        <= '0;
      cmd_ready  <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;

      // Transfer timeout is checked ahead of the per-state edge handling so
      // that it wins over an edge detected in the same cycle.
      if (in_xfer && (cnt == XFER_LAST)) begin
        state      <= ABORT;
        error      <= 1'b1;
        err_code   <= ERR_XFER_TO;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cmd_valid && cmd_ready) begin
              frame      <= {1'b1, odd_parity(cmd_data), cmd_data};
              bitcnt     <= '0;
              cnt        <= '0;
              err_code   <= ERR_NONE;
              cmd_ready  <= 1'b0;
              busy       <= 1'b1;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              state      <= INHIBIT;
            end else begin
              cmd_ready <= 1'b1;
            end
          end

          INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
              cnt        <= '0;
              ps2_dat_oe <= 1'b1;
              state      <= RTS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          RTS: begin
            if (cnt == RTS_LAST) begin
              cnt        <= '0;
              ps2_clk_oe <= 1'b0;
              state      <= WAIT_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          WAIT_START: begin
            if (cnt == START_LAST) begin
              state      <= ABORT;
              error      <= 1'b1;
              err_code   <= ERR_START_TO;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b0;
            end else if (clk_fall) begin
              ps2_dat_oe <= ~frame[0];
              frame      <= {1'b0, frame[9:1]};
              bitcnt     <= 4'd1;
              cnt        <= '0;
              state      <= SEND;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          SEND: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              ps2_dat_oe <= ~frame[0];
              frame      <= {1'b0, frame[9:1]};
              bitcnt     <= bitcnt + 1'b1;
              if (bitcnt == 4'd9) begin
                state <= WAIT_ACK;
              end
            end
          end

          WAIT_ACK: begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              if (!dat_level) begin
                state <= WAIT_IDLE;
              end else begin
                state      <= ABORT;
                error      <= 1'b1;
                err_code   <= ERR_NO_ACK;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
              end
            end
          end

          WAIT_IDLE: begin
            cnt <= cnt + 1'b1;
            if (clk_level && dat_level) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end

          ABORT: begin
            busy  <= 1'b0;
            state <= IDLE;
          end

          default: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Scoreboard bench for ps2_command_tx with an open-drain PS/2 device model.
module tb_ps2_command_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  // Wired-AND of the open-drain lines.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_command_tx #(
    .INHIBIT_CYCLES       (20),
    .RTS_SETUP_CYCLES     (5),
    .START_TIMEOUT_CYCLES (400),
    .XFER_TIMEOUT_CYCLES  (2000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    int         rel_lat;
  } outcome_t;

  outcome_t   sb_q[$];
  logic [9:0] frame_q[$];
  outcome_t   mon_e;

  int errors    = 0;
  int checks    = 0;
  int pulses    = 0;
  int ready_due = 0;
  int rel_cnt   = 0;
  int inh_run   = 0;
  int rts_run   = 0;
  bit prev_clk_oe = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  // Monitor: line-phase timing plus scoreboard pops on every done/error pulse.
  always @(negedge clock) begin
    if (reset) begin
      ready_due   = 0;
      inh_run     = 0;
      rts_run     = 0;
      prev_clk_oe = 1'b0;
    end else begin
      if (ps2_clk_oe) begin
        if (ps2_dat_oe) rts_run++;
        else            inh_run++;
        prev_clk_oe = 1'b1;
      end else begin
        if (prev_clk_oe) begin
          chk("inhibit_len", inh_run, 20);
          chk("rts_len", rts_run, 5);
          rel_cnt = 0;
        end else begin
          rel_cnt++;
        end
        inh_run     = 0;
        rts_run     = 0;
        prev_clk_oe = 1'b0;
      end

      if (ready_due > 0) begin
        ready_due--;
        if (ready_due == 0) chk("ready_after_end", int'(cmd_ready), 1);
      end

      if (done || error) begin
        pulses++;
        if (sb_q.size() == 0) begin
          timeout_fail("unexpected_pulse");
        end else begin
          mon_e = sb_q.pop_front();
          chk("pulse_is_error", int'(error), int'(mon_e.is_err));
          chk("pulse_is_done", int'(done), int'(!mon_e.is_err));
          chk("err_code", int'(err_code), int'(mon_e.code));
          chk("end_clk_oe", int'(ps2_clk_oe), 0);
          chk("end_dat_oe", int'(ps2_dat_oe), 0);
          if (!mon_e.is_err) chk("busy_at_done", int'(busy), 0);
          if (mon_e.rel_lat >= 0) chk("start_to_latency", rel_cnt, mon_e.rel_lat);
          ready_due = mon_e.is_err ? 2 : 1;
        end
      end
    end
  end

  task automatic push_done(input logic [7:0] b, input logic par);
    outcome_t o;
    o.is_err = 1'b0; o.code = ps2_pkg::ERR_NONE; o.rel_lat = -1;
    sb_q.push_back(o);
    frame_q.push_back({1'b1, par, b});
  endtask

  task automatic push_err(input logic [1:0] code, input int lat);
    outcome_t o;
    o.is_err = 1'b1; o.code = code; o.rel_lat = lat;
    sb_q.push_back(o);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = b;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        @(negedge clock);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    timeout_fail("accept");
  endtask

  // Device: waits for request-to-send, clocks `edges` falling edges (20-cycle
  // period), samples data on each rising edge, optionally acks on edge 11.
  task automatic dev_run(input int edges, input bit ack);
    logic [9:0] got;
    logic [9:0] exp;
    int w;
    got = '0;
    w = 0;
    while (!(!ps2_clk_oe && ps2_dat_oe) && w < 500) begin
      @(negedge clock);
      w++;
    end
    if (w >= 500) begin
      timeout_fail("request_to_send");
      return;
    end
    repeat (5) @(negedge clock);
    for (int e = 1; e <= edges; e++) begin
      dev_clk = 1'b0;
      repeat (10) @(negedge clock);
      dev_clk = 1'b1;
      if (e <= 10) got[e-1] = ps2_dat_in;
      if (e == 11) dev_dat = 1'b1;
      repeat (3) @(negedge clock);
      if (e == 10 && ack) dev_dat = 1'b0;
      repeat (7) @(negedge clock);
    end
    if (edges >= 10) begin
      if (frame_q.size() == 0) begin
        timeout_fail("frame_unexpected");
      end else begin
        exp = frame_q.pop_front();
        chk("frame_data", int'(got[7:0]), int'(exp[7:0]));
        chk("frame_parity", int'(got[8]), int'(exp[8]));
        chk("frame_stop", int'(got[9]), int'(exp[9]));
      end
    end
  endtask

  task automatic wait_outcome();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || ready_due != 0) && w < 5000) begin
      @(negedge clock);
      w++;
    end
    if (w >= 5000) timeout_fail("outcome");
  endtask

  int p_snap;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = ps2_pkg::CMD_RESET;
    repeat (3) @(negedge clock);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_dat_oe", int'(ps2_dat_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_error", int'({done, error}), 0);
    chk("rst_err_code", int'(err_code), 0);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", int'(cmd_ready), 1);

    // 1: 0xED, six ones -> parity 1, acked
    push_done(ps2_pkg::CMD_SET_LEDS, 1'b1);
    send_cmd(ps2_pkg::CMD_SET_LEDS);
    chk("busy_after_accept", int'(busy), 1);
    dev_run(11, 1'b1);
    wait_outcome();

    // 2: 0xF4, five ones -> parity 0, acked
    push_done(ps2_pkg::CMD_ENABLE, 1'b0);
    send_cmd(ps2_pkg::CMD_ENABLE);
    dev_run(11, 1'b1);
    wait_outcome();

    // 3: device silent -> start timeout 400 cycles after clock release
    push_err(ps2_pkg::ERR_START_TO, 400);
    send_cmd(8'h55);
    wait_outcome();

    // 4: 0xA5 (four ones -> parity 1), data left high at ack edge
    push_err(ps2_pkg::ERR_NO_ACK, -1);
    frame_q.push_back({1'b1, 1'b1, 8'hA5});
    send_cmd(8'hA5);
    dev_run(11, 1'b0);
    wait_outcome();

    // 5: device stops after 5 edges -> transfer timeout
    push_err(ps2_pkg::ERR_XFER_TO, -1);
    send_cmd(8'h3C);
    dev_run(5, 1'b0);
    wait_outcome();

    // 6: reset mid-SEND while 0x00 is driving a zero bit
    send_cmd(8'h00);
    dev_run(4, 1'b0);
    chk("pre_reset_dat_oe", int'(ps2_dat_oe), 1);
    chk("pre_reset_busy", int'(busy), 1);
    p_snap    = pulses;
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = ps2_pkg::CMD_ENABLE;
    @(negedge clock);
    chk("mid_rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("mid_rst_dat_oe", int'(ps2_dat_oe), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clock);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("no_accept_during_reset", int'(busy), 0);
    chk("no_pulse_on_reset", pulses, p_snap);

    // post-reset 0xFF, eight ones -> parity 1
    push_done(ps2_pkg::CMD_RESET, 1'b1);
    send_cmd(ps2_pkg::CMD_RESET);
    dev_run(11, 1'b1);
    wait_outcome();

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("frames_drained", frame_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
